// File: rtl/spi_xfer_queue_pkg.sv
// spi_xfer_queue shared types: byte width, status bit defaults,
// sequencer state encoding and the sticky-flag update helper.
package spi_xfer_queue_pkg;

  localparam int BYTE_W         = 8;
  localparam int TX_RDY_BIT_DEF = 0;
  localparam int RX_VLD_BIT_DEF = 1;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_READ      = 3'd3,
    ST_CAPTURE   = 3'd4
  } state_e;

  // A set in the same cycle as a clear leaves the flag set.
  function automatic logic sticky(
    input logic q,
    input logic clr,
    input logic set
  );
    return (q & ~clr) | set;
  endfunction

endpackage

// File: rtl/spi_xfer_queue_byte_fifo.sv
// First-word-fall-through byte FIFO with full/empty/level.
// Push while full and pop while empty are ignored.
module spi_xfer_queue_byte_fifo
  import spi_xfer_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  byte_t       push_data,
  input  logic        pop,
  output byte_t       head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  byte_t         mem_q [DEPTH];
  byte_t         mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = empty ? '0 : mem_q[rd_q];

  // Pointer, count and storage update for accepted push/pop.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + AW'(1);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_xfer_queue.sv
// Byte-stream front end for an SPI core: TX FIFO feeds a
// load/wait/read/capture sequencer that fills an RX FIFO.
module spi_xfer_queue
  import spi_xfer_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int TX_RDY_BIT = TX_RDY_BIT_DEF,
  parameter int RX_VLD_BIT = RX_VLD_BIT_DEF,
  parameter int TIMEOUT    = 1024,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          CLR_N,
  input  logic          ENABLE,
  input  logic          PUSH,
  input  logic [7:0]    PUSH_DATA,
  output logic          TX_FULL,
  output logic [LW-1:0] TX_LEVEL,
  input  logic          POP,
  output logic [7:0]    POP_DATA,
  output logic          RX_EMPTY,
  input  logic          ERR_CLR,
  output logic          TX_OVF,
  output logic          RX_OVF,
  output logic          TMO,
  output logic          BUSY,
  output logic          SPI_WRITE,
  output logic [7:0]    SPI_TX_DATA,
  output logic          SPI_READ,
  input  logic [7:0]    SPI_RX_DATA,
  input  logic [7:0]    SPI_STATUS
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  byte_t         txd_q, txd_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic          tmo_q, tmo_d;

  byte_t         tx_head;
  logic          tx_empty;
  logic          tx_pop;
  logic          rx_push;
  logic          rx_full;
  logic [LW-1:0] unused_rx_lvl;
  logic          unused_status;
  logic          tmo_set;
  logic          rx_ovf_set;
  logic          spi_write;
  logic          spi_read;

  assign unused_status = ^SPI_STATUS;

  spi_xfer_queue_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk       (CLK),
    .rst_n     (CLR_N),
    .push      (PUSH),
    .push_data (PUSH_DATA),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (TX_FULL),
    .empty     (tx_empty),
    .level     (TX_LEVEL)
  );

  spi_xfer_queue_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk       (CLK),
    .rst_n     (CLR_N),
    .push      (rx_push),
    .push_data (SPI_RX_DATA),
    .pop       (POP),
    .head      (POP_DATA),
    .full      (rx_full),
    .empty     (RX_EMPTY),
    .level     (unused_rx_lvl)
  );

  // Sequencer next state and per-state strobes.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    spi_write  = 1'b0;
    spi_read   = 1'b0;
    tmo_set    = 1'b0;
    rx_ovf_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ENABLE && !tx_empty && SPI_STATUS[TX_RDY_BIT])
          state_d = ST_LOAD;
      end
      ST_LOAD: begin
        spi_write = 1'b1;
        tx_pop    = 1'b1;
        txd_d     = tx_head;
        tmr_d     = '0;
        state_d   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (SPI_STATUS[RX_VLD_BIT]) begin
          state_d = ST_READ;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          tmo_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_READ: begin
        spi_read = 1'b1;
        state_d  = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        rx_push    = ~rx_full;
        rx_ovf_set = rx_full;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error flags.
  always_comb begin
    tx_ovf_d = sticky(tx_ovf_q, ERR_CLR, PUSH & TX_FULL);
    rx_ovf_d = sticky(rx_ovf_q, ERR_CLR, rx_ovf_set);
    tmo_d    = sticky(tmo_q, ERR_CLR, tmo_set);
  end

  // Sequencer and flag registers.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      txd_q    <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      txd_q    <= txd_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      tmo_q    <= tmo_d;
    end
  end

  assign SPI_WRITE   = spi_write;
  assign SPI_READ    = spi_read;
  assign SPI_TX_DATA = spi_write ? tx_head : txd_q;
  assign BUSY        = (state_q != ST_IDLE);
  assign TX_OVF      = tx_ovf_q;
  assign RX_OVF      = rx_ovf_q;
  assign TMO         = tmo_q;

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Directed bench for spi_xfer_queue: a scripted SPI core and
// TX/RX scoreboard queues check ordering, flags and timeout.
module tb_spi_xfer_queue;

  logic       CLK = 1'b0;
  logic       CLR_N;
  logic       ENABLE;
  logic       PUSH;
  logic [7:0] PUSH_DATA;
  logic       TX_FULL;
  logic [3:0] TX_LEVEL;
  logic       POP;
  logic [7:0] POP_DATA;
  logic       RX_EMPTY;
  logic       ERR_CLR;
  logic       TX_OVF;
  logic       RX_OVF;
  logic       TMO;
  logic       BUSY;
  logic       SPI_WRITE;
  logic [7:0] SPI_TX_DATA;
  logic       SPI_READ;
  logic [7:0] SPI_RX_DATA;
  logic [7:0] SPI_STATUS;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_sb [$];
  logic [7:0] rx_sb [$];

  always #5 CLK = ~CLK;

  spi_xfer_queue #(
    .DEPTH   (8),
    .TIMEOUT (1024)
  ) dut (
    .CLK         (CLK),
    .CLR_N       (CLR_N),
    .ENABLE      (ENABLE),
    .PUSH        (PUSH),
    .PUSH_DATA   (PUSH_DATA),
    .TX_FULL     (TX_FULL),
    .TX_LEVEL    (TX_LEVEL),
    .POP         (POP),
    .POP_DATA    (POP_DATA),
    .RX_EMPTY    (RX_EMPTY),
    .ERR_CLR     (ERR_CLR),
    .TX_OVF      (TX_OVF),
    .RX_OVF      (RX_OVF),
    .TMO         (TMO),
    .BUSY        (BUSY),
    .SPI_WRITE   (SPI_WRITE),
    .SPI_TX_DATA (SPI_TX_DATA),
    .SPI_READ    (SPI_READ),
    .SPI_RX_DATA (SPI_RX_DATA),
    .SPI_STATUS  (SPI_STATUS)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_b(input logic [7:0] b);
    PUSH      = 1'b1;
    PUSH_DATA = b;
    @(negedge CLK);
    PUSH      = 1'b0;
  endtask

  task automatic wait_write();
    int n;
    n = 0;
    while (!SPI_WRITE && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("write_seen", 32'(SPI_WRITE), 1);
  endtask

  task automatic xfer(input logic [7:0] rx, input bit store);
    int n;
    logic [7:0] e;
    wait_write();
    e = (tx_sb.size() > 0) ? tx_sb.pop_front() : 8'h00;
    chk("tx_data", 32'(SPI_TX_DATA), 32'(e));
    @(negedge CLK);
    chk("write_1cyc", 32'(SPI_WRITE), 0);
    chk("tx_hold", 32'(SPI_TX_DATA), 32'(e));
    SPI_STATUS[1] = 1'b1;
    SPI_RX_DATA   = rx;
    n = 0;
    while (!SPI_READ && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("read_seen", 32'(SPI_READ), 1);
    SPI_STATUS[1] = 1'b0;
    if (store) rx_sb.push_back(rx);
    @(negedge CLK);
    chk("read_1cyc", 32'(SPI_READ), 0);
    @(negedge CLK);
  endtask

  task automatic pop_chk();
    logic [7:0] e;
    chk("rx_nonempty", 32'(RX_EMPTY), 0);
    e = (rx_sb.size() > 0) ? rx_sb.pop_front() : 8'h00;
    chk("pop_data", 32'(POP_DATA), 32'(e));
    POP = 1'b1;
    @(negedge CLK);
    POP = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    CLR_N       = 1'b0;
    ENABLE      = 1'b0;
    PUSH        = 1'b0;
    PUSH_DATA   = 8'h00;
    POP         = 1'b0;
    ERR_CLR     = 1'b0;
    SPI_RX_DATA = 8'h00;
    SPI_STATUS  = 8'h01;
    #1;
    chk("rst_tx_full", 32'(TX_FULL), 0);
    chk("rst_tx_level", 32'(TX_LEVEL), 0);
    chk("rst_rx_empty", 32'(RX_EMPTY), 1);
    chk("rst_pop_data", 32'(POP_DATA), 0);
    chk("rst_flags", {29'd0, TX_OVF, RX_OVF, TMO}, 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_strobes", {30'd0, SPI_WRITE, SPI_READ}, 0);
    chk("rst_tx_data", 32'(SPI_TX_DATA), 0);
    @(negedge CLK);
    @(negedge CLK);
    CLR_N = 1'b1;
    @(negedge CLK);

    // single byte round trip
    ENABLE = 1'b1;
    tx_sb.push_back(8'h50);
    push_b(8'h50);
    xfer(8'h4D, 1'b1);
    pop_chk();
    chk("t1_rx_empty", 32'(RX_EMPTY), 1);
    chk("t1_tx_level", 32'(TX_LEVEL), 0);

    // back-to-back pushes
    tx_sb.push_back(8'h54);
    tx_sb.push_back(8'h6C);
    push_b(8'h54);
    push_b(8'h6C);
    xfer(8'h6C, 1'b1);
    xfer(8'h54, 1'b1);
    chk("t2_tx_level", 32'(TX_LEVEL), 0);
    pop_chk();
    pop_chk();
    chk("t2_rx_empty", 32'(RX_EMPTY), 1);

    // TX overflow with sequencer disabled
    ENABLE = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_sb.push_back(8'hA0 + 8'(i));
      push_b(8'hA0 + 8'(i));
    end
    chk("t3_tx_full", 32'(TX_FULL), 1);
    chk("t3_tx_level", 32'(TX_LEVEL), 8);
    chk("t3_tx_ovf", 32'(TX_OVF), 1);
    chk("t3_busy", 32'(BUSY), 0);
    ERR_CLR   = 1'b1;
    PUSH      = 1'b1;
    PUSH_DATA = 8'hFF;
    @(negedge CLK);
    PUSH = 1'b0;
    chk("t3_set_wins", 32'(TX_OVF), 1);
    @(negedge CLK);
    ERR_CLR = 1'b0;
    chk("t3_ovf_clr", 32'(TX_OVF), 0);
    chk("t3_level_kept", 32'(TX_LEVEL), 8);

    // drain TX into RX until RX is full, then overflow RX
    ENABLE = 1'b1;
    for (int i = 0; i < 8; i++) xfer(8'h10 + 8'(i), 1'b1);
    chk("t5_tx_level", 32'(TX_LEVEL), 0);
    chk("t5_rx_nonempty", 32'(RX_EMPTY), 0);
    chk("t5_no_ovf", 32'(RX_OVF), 0);
    tx_sb.push_back(8'hEE);
    push_b(8'hEE);
    xfer(8'h99, 1'b0);
    chk("t5_rx_ovf", 32'(RX_OVF), 1);
    chk("t5_head_kept", 32'(POP_DATA), 32'(rx_sb[0]));
    for (int i = 0; i < 8; i++) pop_chk();
    chk("t5_rx_empty", 32'(RX_EMPTY), 1);
    POP = 1'b1;
    @(negedge CLK);
    POP = 1'b0;
    chk("t5_pop_empty", 32'(RX_EMPTY), 1);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    chk("t5_ovf_clr", 32'(RX_OVF), 0);

    // WAIT_DONE timeout
    tx_sb.push_back(8'h77);
    push_b(8'h77);
    wait_write();
    chk("t4_tx_data", 32'(SPI_TX_DATA), 32'(tx_sb.pop_front()));
    n = 0;
    while (n < 1100) begin
      @(negedge CLK);
      n++;
      if (n == 1) chk("t4_busy", 32'(BUSY), 1);
      if (TMO) break;
    end
    chk("t4_tmo_lat", 32'(n), 1025);
    chk("t4_tmo", 32'(TMO), 1);
    chk("t4_busy_idle", 32'(BUSY), 0);
    chk("t4_rx_empty", 32'(RX_EMPTY), 1);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    chk("t4_tmo_clr", 32'(TMO), 0);

    // async reset in WAIT_DONE
    push_b(8'h31);
    push_b(8'h32);
    wait_write();
    @(negedge CLK);
    chk("t6_busy", 32'(BUSY), 1);
    chk("t6_tx_level", 32'(TX_LEVEL), 1);
    #2 CLR_N = 1'b0;
    #1;
    chk("t6_busy_rst", 32'(BUSY), 0);
    chk("t6_strobes", {30'd0, SPI_WRITE, SPI_READ}, 0);
    chk("t6_tx_level_rst", 32'(TX_LEVEL), 0);
    chk("t6_rx_empty", 32'(RX_EMPTY), 1);
    chk("t6_tx_data", 32'(SPI_TX_DATA), 0);
    tx_sb.delete();
    @(negedge CLK);
    CLR_N = 1'b1;
    @(negedge CLK);
    chk("t6_idle", 32'(BUSY), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_queue.md
Name: spi_xfer_queue

Overview:
- Byte-stream front end placed directly upstream/downstream of the SPI core's parallel side.
- Host pushes TX bytes into a TX FIFO; sequencer loads each byte into the SPI core (WRITE strobe), waits for transfer completion via STATUS, pulses READ, and captures the received byte into an RX FIFO for the host.
- Decouples host timing from SPI byte timing; one instance per SPI core, master or slave.

Parameters:
- DEPTH, 8, entries per FIFO; power of 2, ≥2.
- TX_RDY_BIT, 0, SPI STATUS bit index: core can accept a new WRITE.
- RX_VLD_BIT, 1, SPI STATUS bit index: received byte available; core clears it on READ.
- TIMEOUT, 1024, max CLK cycles in WAIT_DONE before abort.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- CLR_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  sequencer may start new bytes when 1.
- PUSH  in  1  write PUSH_DATA into TX FIFO.
- PUSH_DATA  in  8  TX byte.
- TX_FULL  out  1  TX FIFO full.
- TX_LEVEL  out  log2(DEPTH)+1  TX occupancy.
- POP  in  1  remove head of RX FIFO.
- POP_DATA  out  8  RX head, first-word-fall-through.
- RX_EMPTY  out  1  RX FIFO empty.
- ERR_CLR  in  1  clears sticky flags.
- TX_OVF  out  1  sticky: PUSH while TX_FULL.
- RX_OVF  out  1  sticky: captured byte dropped because RX full.
- TMO  out  1  sticky: WAIT_DONE timeout.
- BUSY  out  1  sequencer not in IDLE.
- SPI_WRITE  out  1  one-cycle load strobe to core.
- SPI_TX_DATA  out  8  byte presented to core.
- SPI_READ  out  1  one-cycle read strobe to core.
- SPI_RX_DATA  in  8  byte from core.
- SPI_STATUS  in  8  core status.

Behaviour:
- Reset (CLR_N=0, async): both FIFOs empty, pointers 0, state IDLE. All outputs 0 except RX_EMPTY=1; SPI_TX_DATA=0.
- FIFOs: PUSH when full ignored and sets TX_OVF. POP when empty ignored. Simultaneous push+pop on one FIFO: both succeed, level unchanged; when empty, pop ignored and push succeeds. Pointers wrap modulo DEPTH.
- IDLE: if ENABLE & TX not empty & SPI_STATUS[TX_RDY_BIT] → LOAD.
- LOAD (1 cycle): SPI_WRITE=1, SPI_TX_DATA=TX head; pop TX FIFO; clear timeout counter → WAIT_DONE.
- WAIT_DONE: SPI_STATUS[RX_VLD_BIT]=1 → READ. Counter reaches TIMEOUT-1 → set TMO, go IDLE, drop byte (no RX push).
- READ (1 cycle): SPI_READ=1 → CAPTURE.
- CAPTURE (1 cycle): sample SPI_RX_DATA. Push to RX FIFO if not full, else set RX_OVF. → IDLE.
- Minimum turnaround: IDLE→LOAD→WAIT_DONE(≥1)→READ→CAPTURE→IDLE = 5 cycles/byte.
- SPI_TX_DATA holds its last loaded value outside LOAD.
- ENABLE deasserted mid-byte: current byte completes; no new LOAD.
- ERR_CLR clears TX_OVF/RX_OVF/TMO. A same-cycle set event wins.
- BUSY=1 in every state except IDLE.
- Status inputs are assumed synchronous to CLK (same-clock core); no synchronizers.

Decomposition:
- Shared include spi_defs.vh: state encodings (IDLE, LOAD, WAIT_DONE, READ, CAPTURE), default STATUS bit indices, byte width constant.
- Sub-module byte_fifo (DEPTH parameter; FWFT, full/empty/level): instantiated twice, TX and RX.

Test Plan:
- Reset then PUSH 8'h50 with ENABLE=1, STATUS[0]=1 → SPI_WRITE pulse with SPI_TX_DATA=8'h50 within 2 cycles. Set STATUS[1]=1 with SPI_RX_DATA=8'h4D → SPI_READ pulse, then RX_EMPTY=0, POP_DATA=8'h4D.
- PUSH 8'h54, 8'h6C back-to-back, core replies 8'h6C, 8'h54 → two WRITE strobes in order 54, 6C; RX pops 6C then 54; TX_LEVEL returns to 0.
- Push DEPTH+1 bytes with ENABLE=0 → TX_FULL=1, TX_LEVEL=8, TX_OVF=1; ERR_CLR → TX_OVF=0, contents intact.
- Load byte, hold STATUS[1]=0 for TIMEOUT cycles → TMO=1, BUSY=0, RX_EMPTY stays 1.
- Fill RX (8 transfers, no POP), 9th transfer → RX_OVF=1, POP_DATA still first byte.
- Assert CLR_N=0 in WAIT_DONE → immediate IDLE, FIFOs empty, SPI_WRITE/SPI_READ=0.
